// File: rtl/rand_spawn_pkg.sv
// Shared types and defaults for the random obstacle spawn scheduler.
package rand_spawn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    GAP     = 2'd2,
    OFFER   = 2'd3
  } state_e;

  localparam int WORD_W_DEF  = 8;
  localparam int LANE_W_DEF  = 2;
  localparam int GAP_MIN_DEF = 16;

  // Gap field is the low (word_w - lane_w) bits of the word.
  function automatic int unsigned gap_of(
    input int unsigned w,
    input int unsigned word_w,
    input int unsigned lane_w,
    input int unsigned gmin
  );
    int unsigned mask;
    mask = (32'd1 << (word_w - lane_w)) - 32'd1;
    return gmin + (w & mask);
  endfunction

endpackage

// File: rtl/rand_spawn_sched_bit_deser.sv
// Serial-to-parallel collector: WORD_W bit shift register plus bit counter.
module bit_deser
  import rand_spawn_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clr,
  input  logic              bit_in,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);

  localparam int CW = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] shreg_q;
  logic [CW-1:0]     cnt_q;

  // word is the value after this edge's shift, so it is valid with word_done
  assign word      = {shreg_q[WORD_W-2:0], bit_in};
  assign word_done = shift_en && (cnt_q == CW'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (shift_en) begin
      shreg_q <= word;
      cnt_q   <= word_done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/rand_spawn_sched.sv
// Turns the serial random bitstream into lane/delay spawn requests.
// Optional lane guard: define RAND_SPAWN_LANE_GUARD_EN.
module rand_spawn_sched
  import rand_spawn_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int LANE_W  = LANE_W_DEF,
  parameter int GAP_MIN = GAP_MIN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              bit_in,
  output logic              spawn_valid,
  input  logic              spawn_ready,
  output logic [LANE_W-1:0] spawn_lane,
  output logic              busy
);

  localparam int GW = WORD_W - LANE_W + 8;

  state_e            state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [LANE_W-1:0] field, lane_pick;
  logic [WORD_W-1:0] word;
  logic              word_done;
  logic              shift_en, clr, hs;

  assign hs       = (state_q == OFFER) && spawn_ready;
  assign shift_en = (state_q == COLLECT) && enable;
  assign clr      = (state_q == IDLE) || hs;
  assign field    = word[WORD_W-1 -: LANE_W];

  bit_deser #(.WORD_W(WORD_W)) u_deser (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr      (clr),
    .bit_in   (bit_in),
    .word     (word),
    .word_done(word_done)
  );

`ifdef RAND_SPAWN_LANE_GUARD_EN
  logic [LANE_W-1:0] prev_q;
  logic              prev_ok_q;

  // Bump to the next lane so consecutive spawns never share one
  assign lane_pick = (prev_ok_q && field == prev_q) ?
                     field + LANE_W'(1) : field;

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
    end else if (hs) begin
      prev_q    <= lane_q;
      prev_ok_q <= 1'b1;
    end
  end
`else
  assign lane_pick = field;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = COLLECT;
      COLLECT: if (word_done) state_d = GAP;
      GAP:     if (enable && gap_q == '0) state_d = OFFER;
      OFFER:   if (spawn_ready) state_d = COLLECT;
    endcase
  end

  always_comb begin
    spawn_valid = (state_q == OFFER);
    busy        = (state_q != IDLE);
    spawn_lane  = lane_q;
  end

  always_comb begin
    gap_d  = gap_q;
    lane_d = lane_q;
    if (word_done) begin
      gap_d  = GW'(gap_of(32'(word), WORD_W, LANE_W, GAP_MIN));
      lane_d = lane_pick;
    end else if (state_q == GAP && enable && gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gap_q  <= '0;
      lane_q <= '0;
    end else begin
      gap_q  <= gap_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: tb/tb_rand_spawn_sched.sv
// Randomised bench for rand_spawn_sched against an enabled-edge counting model.
module tb_rand_spawn_sched;

  localparam int WW   = 8;
  localparam int LW   = 2;
  localparam int GMIN = 16;

`ifdef RAND_SPAWN_LANE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, enable, bit_in, spawn_ready;
  logic          spawn_valid, busy;
  logic [LW-1:0] spawn_lane;

  int checks = 0;
  int errors = 0;

  bit            has_prev = 1'b0;
  logic [LW-1:0] prev_lane = '0;

  always #5 clk = ~clk;

  rand_spawn_sched dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bit_in     (bit_in),
    .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready),
    .spawn_lane (spawn_lane),
    .busy       (busy)
  );

  task automatic step(input bit e, input bit b, input bit r);
    enable      = e;
    bit_in      = b;
    spawn_ready = r;
    @(posedge clk);
    #1;
  endtask

  function automatic bit coin();
    return ($urandom() & 1) != 0;
  endfunction

  // Returns the edge index after which the offer appears, and the captured word.
  function automatic int predict(input bit from_idle, input bit en[$],
                                 input bit bt[$], output logic [WW-1:0] w);
    bit started;
    int nb;
    int left;
    started = !from_idle;
    nb = 0;
    left = 0;
    w = '0;
    for (int e = 0; e < en.size(); e++) begin
      if (en[e]) begin
        if (!started) begin
          started = 1'b1;
        end else if (nb < WW) begin
          w = {w[WW-2:0], bt[e]};
          nb++;
          if (nb == WW) left = GMIN + int'(w[WW-LW-1:0]) + 1;
        end else begin
          left--;
          if (left == 0) return e;
        end
      end
    end
    return -1;
  endfunction

  task automatic run_word(input bit from_idle, input logic [WW-1:0] w,
                          input int ps, input int pl, input int hold,
                          input bit rdy_early, input bit finish_hs,
                          output int obs, output logic [LW-1:0] obs_lane);
    bit en[$];
    bit bt[$];
    int n;
    int nb;
    int oe;
    bit started;
    logic [WW-1:0] wm;
    logic [LW-1:0] field, exp_lane;
    n = 100 + pl;
    nb = 0;
    started = !from_idle;
    for (int e = 0; e < n; e++) begin
      en.push_back(!(e >= ps && e < ps + pl));
      bt.push_back(coin());
    end
    for (int e = 0; e < n; e++) begin
      if (en[e]) begin
        if (!started) started = 1'b1;
        else if (nb < WW) begin
          bt[e] = w[WW-1-nb];
          nb++;
        end
      end
    end
    oe = predict(from_idle, en, bt, wm);
    field = wm[WW-1 -: LW];
    exp_lane = (GUARD && has_prev && field == prev_lane) ?
               field + LW'(1) : field;
    obs = -1;
    obs_lane = '0;
    checks++;
    if (oe < 0) begin
      errors++;
      $display("FAIL model_offer: got %0d want >=0", oe);
    end
    for (int e = 0; e < n && e <= oe; e++) begin
      step(en[e], bt[e], rdy_early);
      if (spawn_valid === 1'b1 && obs < 0) begin
        obs = e;
        obs_lane = spawn_lane;
      end
      checks++;
      if (spawn_valid !== (e == oe)) begin
        errors++;
        $display("FAIL valid_timing edge %0d: got %b want %b",
                 e, spawn_valid, (e == oe));
      end
    end
    checks++;
    if (spawn_lane !== exp_lane || busy !== 1'b1) begin
      errors++;
      $display("FAIL offer_lane: got lane %0d busy %b want lane %0d busy 1",
               spawn_lane, busy, exp_lane);
    end
    for (int h = 0; h < hold; h++) begin
      step(coin(), coin(), 1'b0);
      checks++;
      if (spawn_valid !== 1'b1 || spawn_lane !== exp_lane) begin
        errors++;
        $display("FAIL hold %0d: got v=%b lane=%0d want v=1 lane=%0d",
                 h, spawn_valid, spawn_lane, exp_lane);
      end
    end
    if (finish_hs) begin
      step(coin(), coin(), 1'b1);
      checks++;
      if (spawn_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL handshake: got v=%b busy=%b want v=0 busy=1",
                 spawn_valid, busy);
      end
      has_prev = 1'b1;
      prev_lane = exp_lane;
    end
  endtask

  task automatic quick_reset();
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    has_prev = 1'b0;
  endtask

  task automatic test_reset();
    int o;
    logic [LW-1:0] l;
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (spawn_valid !== 1'b0 || busy !== 1'b0 || spawn_lane !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b busy=%b lane=%0d want 0 0 0",
               spawn_valid, busy, spawn_lane);
    end
    rst = 1'b1;
    run_word(1'b1, {2'b11, 6'($urandom())}, -1, 0, 3, 1'b0, 1'b0, o, l);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, coin(), 1'b1);
      checks++;
      if (spawn_valid !== 1'b0 || busy !== 1'b0 || spawn_lane !== '0) begin
        errors++;
        $display("FAIL reset_offer %0d: got v=%b busy=%b lane=%0d want 0 0 0",
                 i, spawn_valid, busy, spawn_lane);
      end
    end
    rst = 1'b1;
    has_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, coin(), 1'b1);
      checks++;
      if (spawn_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold %0d: got v=%b busy=%b want 0 0",
                 i, spawn_valid, busy);
      end
    end
  endtask

  task automatic test_basic();
    int o;
    logic [LW-1:0] l;
    run_word(1'b1, 8'hB2, -1, 0, 0, 1'b1, 1'b1, o, l);
    checks++;
    if (o !== 75 || l !== 2'd2) begin
      errors++;
      $display("FAIL basic_spawn: got edge %0d lane %0d want 75 lane 2", o, l);
    end
  endtask

  task automatic test_min_gap();
    int o;
    logic [LW-1:0] l;
    quick_reset();
    run_word(1'b1, 8'h00, -1, 0, 0, 1'b1, 1'b1, o, l);
    checks++;
    if (o !== 25 || l !== 2'd0) begin
      errors++;
      $display("FAIL min_gap: got edge %0d lane %0d want 25 lane 0", o, l);
    end
  endtask

  task automatic test_backpressure();
    int o;
    logic [LW-1:0] l;
    run_word(1'b0, WW'($urandom()), -1, 0, 20, 1'b0, 1'b1, o, l);
  endtask

  task automatic test_pause();
    int b, o;
    logic [LW-1:0] l;
    logic [WW-1:0] w;
    w = WW'($urandom());
    run_word(1'b0, w, -1, 0, 0, 1'b1, 1'b1, b, l);
    run_word(1'b0, w, 20, 10, 0, 1'b1, 1'b1, o, l);
    checks++;
    if (o !== b + 10) begin
      errors++;
      $display("FAIL pause_gap: got edge %0d want %0d", o, b + 10);
    end
    run_word(1'b0, w, 3, 10, 0, 1'b1, 1'b1, o, l);
    checks++;
    if (o !== b + 10) begin
      errors++;
      $display("FAIL pause_collect: got edge %0d want %0d", o, b + 10);
    end
  endtask

  task automatic test_guard();
    int o;
    logic [LW-1:0] l1, l2;
    quick_reset();
    run_word(1'b1, {2'b11, 6'($urandom())}, -1, 0, 0, 1'b0, 1'b1, o, l1);
    run_word(1'b0, {2'b11, 6'($urandom())}, -1, 0, 0, 1'b0, 1'b1, o, l2);
    checks++;
    if (l1 !== 2'd3 || l2 !== (GUARD ? 2'd0 : 2'd3)) begin
      errors++;
      $display("FAIL guard_lanes: got %0d,%0d want 3,%0d",
               l1, l2, GUARD ? 0 : 3);
    end
  endtask

  task automatic test_random();
    int o, ps, pl, hold;
    bit re;
    logic [LW-1:0] l;
    for (int i = 0; i < 10; i++) begin
      pl = $urandom_range(0, 12);
      ps = $urandom_range(0, 60);
      re = coin();
      hold = re ? 0 : $urandom_range(0, 5);
      run_word(1'b0, WW'($urandom()), ps, pl, hold, re, 1'b1, o, l);
    end
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    bit_in = 1'b0;
    spawn_ready = 1'b0;
    test_reset();
    test_basic();
    test_min_gap();
    test_backpressure();
    test_pause();
    test_guard();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_spawn_sched.md
Name: rand_spawn_sched

Overview:
- Consumer end of the serial random bitstream: takes the one-bit-per-cycle output of the LFSR number generator, deserialises it into WORD_W-bit words, and turns each word into an obstacle spawn request (lane + delay).
- Sits between the number generator and the obstacle/render logic.
- Offers each spawn over a valid/ready handshake.

Parameters:
- WORD_W, 8, random bits collected per spawn; must be > LANE_W.
- LANE_W, 2, lane index width; 2^LANE_W lanes.
- GAP_MIN, 16, minimum delay in enabled cycles between word capture and offer; must be < 256.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-low.
- enable  input  1  game running; 0 = paused.
- bit_in  input  1  serial random bit from the number generator.
- spawn_valid  output  1  spawn request pending.
- spawn_ready  input  1  obstacle logic accepts request.
- spawn_lane  output  LANE_W  lane of pending spawn.
- busy  output  1  state != IDLE.

Behaviour:
- All state is updated on rising clk. rst==0 at an edge forces:
  - state IDLE; shreg=0, bit_cnt=0, gap_cnt=0
  - spawn_valid=0, spawn_lane=0, busy=0
  - prev_lane=0, prev_ok=0
- This holds even mid-COLLECT/GAP/OFFER; a pending spawn is dropped.
- Field split of captured word W:
  - lane field = W[WORD_W-1 -: LANE_W]
  - gap field = W[WORD_W-LANE_W-1:0]
  - gap = GAP_MIN + gap field, zero-extended; gap_cnt width = (WORD_W-LANE_W)+8, no overflow possible.
- IDLE:
  - enable=1 -> COLLECT, bit_cnt=0. No bit sampled in IDLE.
- COLLECT:
  - Each edge with enable=1: shreg <= {shreg[WORD_W-2:0], bit_in}, so the first bit lands at the MSB; bit_cnt++.
  - On the edge sampling bit WORD_W (bit_cnt==WORD_W-1): form W from the shifted value, latch spawn_lane (see Optional Feature), gap_cnt=gap, go to GAP.
  - enable=0: hold everything.
- GAP:
  - Each enabled edge: if gap_cnt==0 -> OFFER, else gap_cnt--.
  - Duration is gap+1 enabled edges. enable=0 freezes the countdown.
- OFFER:
  - spawn_valid=1 and spawn_lane stable until handshake.
  - Ignores enable; valid is never withdrawn.
  - Edge with spawn_ready=1: handshake. spawn_valid=0, prev_lane=spawn_lane, prev_ok=1, bit_cnt=0, next state COLLECT.
  - spawn_ready high in any state other than OFFER has no effect.
- No bits are sampled during GAP or OFFER; the stream is resumed, not buffered.
- Zero-wait handshake: ready already high when OFFER is entered -> valid high for exactly one cycle.
- With spawn_ready tied high, back-to-back spawns are separated by 1 OFFER + WORD_W + gap+1 cycles.

Optional Feature:
- Macro: RAND_SPAWN_LANE_GUARD_EN.
- Defined: if prev_ok==1 and the lane field == prev_lane, spawn_lane = lane field + 1 mod 2^LANE_W, so no two consecutive spawns share a lane.
- Undefined: spawn_lane = raw lane field; prev_lane/prev_ok are not implemented.

Decomposition:
- Package rand_spawn_pkg:
  - state encoding IDLE/COLLECT/GAP/OFFER (2-bit)
  - default parameter constants
  - helper function computing gap from W
- Sub-module bit_deser: WORD_W shift register plus bit counter.
  - Inputs: clk, rst, shift_en, clr, bit_in.
  - Outputs: word, word_done (asserted combinationally on the edge-sampling cycle of bit WORD_W).
- FSM, gap counter and lane logic stay in the top.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-OFFER -> spawn_valid=0, busy=0, state IDLE on the first edge; no handshake completes.
- Basic spawn (defaults, ready tied 1): enable=1 at edge 1, bit_in 1,0,1,1,0,0,1,0 on edges 2–9 -> W=8'hB2, lane=2, gap=16+50=66; spawn_valid high after edge 76, spawn_lane=2, low after edge 77.
- Minimum gap: bits all 0 -> lane 0, gap 16, spawn_valid high after edge 1+8+17=26.
- Pause: drop enable for 10 cycles during GAP -> offer delayed exactly 10 cycles; same pause during COLLECT -> identical W captured, offer delayed 10 cycles.
- Backpressure: spawn_ready=0 for 20 cycles in OFFER -> spawn_valid and spawn_lane stable for all 20; single acceptance on ready; bit counter restarts at 0.
- Guard (macro defined): two consecutive words with lane field 3 -> lanes 3 then 0. Macro undefined -> lanes 3 then 3.
